// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES-128 decryption sequencer: walks a shared inverse-round datapath
// through the initial AddRoundKey, nine full inverse rounds and the final round.
module aes_inv_round_ctrl #(
   parameter int ROUND_LAT  = 2,
   parameter int NUM_ROUNDS = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         abort,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         rnd_start,
   output logic [1:0]   rnd_sel,
   output logic [3:0]   key_idx,
   output logic [127:0] rnd_data_o,
   input  logic [127:0] rnd_data_i,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy,
   output logic [3:0]   pass_cnt
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   localparam logic [3:0] LAST_PASS = 4'(NUM_ROUNDS);
   localparam logic [3:0] WAIT_INIT = 4'(ROUND_LAT - 1);

   state_t       r_state;
   state_t       w_nextState;
   logic [127:0] r_stateQ;
   logic [3:0]   r_passCnt;
   logic [3:0]   r_waitCnt;
   logic         w_accept;
   logic         w_capture;

   // Abort blocks both acceptance and the result capture in the same cycle.
   assign w_accept  = (r_state == IDLE) && in_valid && !abort;
   assign w_capture = (r_state == WAIT) && (r_waitCnt == 4'd0) && !abort;

   always_comb begin
      w_nextState = r_state;
      in_ready    = 1'b0;
      rnd_start   = 1'b0;
      out_valid   = 1'b0;
      unique case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (w_accept) w_nextState = ISSUE;
         end
         ISSUE: begin
            rnd_start   = 1'b1;
            w_nextState = WAIT;
         end
         WAIT: begin
            if (w_capture) w_nextState = (r_passCnt == LAST_PASS) ? DONE : ISSUE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_nextState = IDLE;
         end
         default: w_nextState = IDLE;
      endcase
      if (abort) w_nextState = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_nextState;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stateQ  <= '0;
         r_passCnt <= '0;
         r_waitCnt <= '0;
      end else if (abort) begin
         r_passCnt <= '0;
      end else begin
         if (w_accept) begin
            r_stateQ  <= in_data;
            r_passCnt <= '0;
         end
         if (r_state == ISSUE) r_waitCnt <= WAIT_INIT;
         if (r_state == WAIT && r_waitCnt != 4'd0) r_waitCnt <= r_waitCnt - 4'd1;
         if (w_capture) begin
            r_stateQ <= rnd_data_i;
            if (r_passCnt != LAST_PASS) r_passCnt <= r_passCnt + 4'd1;
         end
      end
   end

   // Pass 0 is the bare AddRoundKey with the last round key; the final pass skips InvMixColumns.
   always_comb begin
      rnd_sel = 2'd1;
      if (r_passCnt == 4'd0)           rnd_sel = 2'd0;
      else if (r_passCnt == LAST_PASS) rnd_sel = 2'd2;
   end

   assign key_idx    = LAST_PASS - r_passCnt;
   assign rnd_data_o = r_stateQ;
   assign out_data   = r_stateQ;
   assign busy       = (r_state != IDLE);
   assign pass_cnt   = r_passCnt;

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Directed bench for aes_inv_round_ctrl: three lanes (ROUND_LAT 2, 1, 15), each with a
// behavioural inverse-round datapath and key store built from the FIPS-197 C.1 key.
module tb_aes_inv_round_ctrl;

   localparam logic [127:0] KEY     = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT      = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT      = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] GARBAGE = 128'hdeadbeef_0badf00d_cafebabe_55aa55aa;

   logic         clk  = 1'b0;
   logic         rstN = 1'b1;
   logic [127:0] inData;
   logic         inValid[3];
   logic         abortIn[3];
   logic         outReady[3];
   logic         inReady[3];
   logic         rndStart[3];
   logic         outValid[3];
   logic         busy[3];
   logic [1:0]   rndSel[3];
   logic [3:0]   keyIdx[3];
   logic [3:0]   passCnt[3];
   logic [127:0] rndDataO[3];
   logic [127:0] outData[3];

   logic [7:0]   sbox[256];
   logic [7:0]   isbox[256];
   logic [127:0] rk[11];

   int checkCount = 0;
   int badCount   = 0;

   always #5 clk = ~clk;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      logic [7:0] y;
      p = 8'h00;
      x = a;
      y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   // Reference inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then optional InvMixColumns.
   function automatic logic [127:0] invRound(input logic [127:0] s, input logic [1:0] sel,
                                             input logic [3:0] kIdx);
      logic [7:0]   b[16];
      logic [7:0]   t[16];
      logic [127:0] r;
      logic [7:0]   a0, a1, a2, a3;
      if (sel == 2'd0) return s ^ rk[kIdx];
      for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
      for (int c = 0; c < 4; c++)
         for (int rr = 0; rr < 4; rr++)
            t[c*4+rr] = isbox[b[((c - rr + 4) % 4)*4 + rr]];
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
      r = r ^ rk[kIdx];
      if (sel == 2'd1) begin
         for (int c = 0; c < 4; c++) begin
            a0 = r[127-32*c -: 8];
            a1 = r[119-32*c -: 8];
            a2 = r[111-32*c -: 8];
            a3 = r[103-32*c -: 8];
            r[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            r[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            r[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            r[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
         end
      end
      return r;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : gLane
      localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
      logic [4:0]   dpCnt = 5'd0;
      logic [127:0] dpRes = '0;
      logic [127:0] dpOut;

      // The result is only valid in the single cycle before the sampling edge.
      assign dpOut = (dpCnt == 5'd1) ? dpRes : GARBAGE;

      always @(posedge clk) begin
         if (dpCnt != 5'd0) dpCnt <= dpCnt - 5'd1;
         if (rndStart[g]) begin
            dpCnt <= 5'(LAT);
            dpRes <= invRound(rndDataO[g], rndSel[g], keyIdx[g]);
         end
      end

      aes_inv_round_ctrl #(.ROUND_LAT(LAT)) uDut (
         .clk        (clk),
         .rst_n      (rstN),
         .abort      (abortIn[g]),
         .in_valid   (inValid[g]),
         .in_ready   (inReady[g]),
         .in_data    (inData),
         .rnd_start  (rndStart[g]),
         .rnd_sel    (rndSel[g]),
         .key_idx    (keyIdx[g]),
         .rnd_data_o (rndDataO[g]),
         .rnd_data_i (dpOut),
         .out_valid  (outValid[g]),
         .out_ready  (outReady[g]),
         .out_data   (outData[g]),
         .busy       (busy[g]),
         .pass_cnt   (passCnt[g])
      );
   end

   task automatic buildTables();
      logic [7:0]   inv, x, s, rc;
      logic [31:0]  w[44];
      logic [31:0]  tmp;
      logic [127:0] keyVar;
      for (int i = 0; i < 256; i++) begin
         inv = 8'h00;
         for (int j = 1; j < 256; j++)
            if (gmul(8'(i), 8'(j)) == 8'h01) inv = 8'(j);
         s = inv;
         x = inv;
         for (int k = 0; k < 4; k++) begin
            x = {x[6:0], x[7]};
            s = s ^ x;
         end
         s = s ^ 8'h63;
         sbox[i]  = s;
         isbox[s] = 8'(i);
      end
      keyVar = KEY;
      for (int i = 0; i < 4; i++) w[i] = keyVar[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]} ^ {rc, 24'h0};
            rc  = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checkCount++;
      if (got !== exp) begin
         badCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Offers one block at a negedge; the following rising edge is cycle 0.
   task automatic applyStimulus(input int k, input logic [127:0] data);
      @(negedge clk);
      inData     = data;
      inValid[k] = 1'b1;
      checkOutput("in_ready before accept", 128'(inReady[k]), 128'(1));
      @(posedge clk);
      #1 inValid[k] = 1'b0;
   endtask

   task automatic waitForResult(input int k, input int lat, input int expCycle,
                                input logic [127:0] expPt);
      int         gotCycle;
      int         pCyc[$];
      logic [3:0] pKey[$];
      logic [1:0] pSel[$];
      logic [1:0] expSel;
      gotCycle = -1;
      for (int n = 1; n <= 400 && gotCycle < 0; n++) begin
         @(negedge clk);
         if (rndStart[k]) begin
            pCyc.push_back(n);
            pKey.push_back(keyIdx[k]);
            pSel.push_back(rndSel[k]);
         end
         if (outValid[k]) gotCycle = n;
      end
      checkOutput("out_valid within budget", 128'(outValid[k]), 128'(1));
      checkOutput("out_valid cycle", 128'(gotCycle), 128'(expCycle));
      checkOutput("plaintext", outData[k], expPt);
      checkOutput("rnd_start pulse count", 128'(pCyc.size()), 128'(11));
      for (int j = 0; j < pCyc.size() && j < 11; j++) begin
         expSel = (j == 0) ? 2'd0 : ((j == 10) ? 2'd2 : 2'd1);
         checkOutput("rnd_start cycle", 128'(pCyc[j]), 128'(1 + j*(lat + 1)));
         checkOutput("key_idx", 128'(pKey[j]), 128'(10 - j));
         checkOutput("rnd_sel", 128'(pSel[j]), 128'(expSel));
      end
   endtask

   task automatic releaseOutput(input int k);
      outReady[k] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      outReady[k] = 1'b0;
      checkOutput("busy after handshake", 128'(busy[k]), 128'(0));
      checkOutput("out_valid after handshake", 128'(outValid[k]), 128'(0));
      checkOutput("in_ready after handshake", 128'(inReady[k]), 128'(1));
   endtask

   initial begin
      logic [127:0] held;
      int           bad;
      bit           found;

      for (int k = 0; k < 3; k++) begin
         inValid[k]  = 1'b0;
         abortIn[k]  = 1'b0;
         outReady[k] = 1'b0;
      end
      inData = '0;
      #1 rstN = 1'b0;
      buildTables();
      repeat (2) @(negedge clk);

      checkOutput("reset in_ready", 128'(inReady[0]), 128'(1));
      checkOutput("reset rnd_start", 128'(rndStart[0]), 128'(0));
      checkOutput("reset rnd_sel", 128'(rndSel[0]), 128'(0));
      checkOutput("reset key_idx", 128'(keyIdx[0]), 128'(10));
      checkOutput("reset out_valid", 128'(outValid[0]), 128'(0));
      checkOutput("reset busy", 128'(busy[0]), 128'(0));
      checkOutput("reset out_data", outData[0], 128'(0));
      checkOutput("reset pass_cnt", 128'(passCnt[0]), 128'(0));
      rstN = 1'b1;

      $display("[TB] FIPS vector, ROUND_LAT=2");
      applyStimulus(0, CT);
      waitForResult(0, 2, 34, PT);

      $display("[TB] output backpressure");
      held = outData[0];
      bad  = 0;
      repeat (20) begin
         @(negedge clk);
         if (outValid[0] !== 1'b1 || outData[0] !== held || inReady[0] !== 1'b0 ||
             rndStart[0] !== 1'b0 || busy[0] !== 1'b1) bad++;
      end
      checkOutput("backpressure violations", 128'(bad), 128'(0));
      releaseOutput(0);

      $display("[TB] abort in IDLE with in_valid");
      @(negedge clk);
      inData     = CT;
      inValid[0] = 1'b1;
      abortIn[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      inValid[0] = 1'b0;
      abortIn[0] = 1'b0;
      checkOutput("abort idle blocks accept", 128'(busy[0]), 128'(0));

      $display("[TB] abort in WAIT of pass 5");
      applyStimulus(0, CT);
      found = 1'b0;
      for (int n = 0; n < 100 && !found; n++) begin
         @(negedge clk);
         if (passCnt[0] == 4'd5 && busy[0] && !rndStart[0]) found = 1'b1;
      end
      checkOutput("reached pass 5 wait", 128'(passCnt[0]), 128'(5));
      held       = outData[0];
      abortIn[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      abortIn[0] = 1'b0;
      checkOutput("abort busy", 128'(busy[0]), 128'(0));
      checkOutput("abort pass_cnt", 128'(passCnt[0]), 128'(0));
      checkOutput("abort in_ready", 128'(inReady[0]), 128'(1));
      bad = 0;
      repeat (6) begin
         @(negedge clk);
         if (outValid[0] || rndStart[0] || busy[0]) bad++;
      end
      checkOutput("post-abort activity", 128'(bad), 128'(0));
      checkOutput("state kept after abort", outData[0], held);
      applyStimulus(0, CT);
      waitForResult(0, 2, 34, PT);
      releaseOutput(0);

      $display("[TB] reset during pass 7");
      applyStimulus(0, CT);
      found = 1'b0;
      for (int n = 0; n < 100 && !found; n++) begin
         @(negedge clk);
         if (passCnt[0] == 4'd7) found = 1'b1;
      end
      checkOutput("reached pass 7", 128'(passCnt[0]), 128'(7));
      #2 rstN = 1'b0;
      #1;
      checkOutput("async reset in_ready", 128'(inReady[0]), 128'(1));
      checkOutput("async reset rnd_start", 128'(rndStart[0]), 128'(0));
      checkOutput("async reset rnd_sel", 128'(rndSel[0]), 128'(0));
      checkOutput("async reset key_idx", 128'(keyIdx[0]), 128'(10));
      checkOutput("async reset out_valid", 128'(outValid[0]), 128'(0));
      checkOutput("async reset busy", 128'(busy[0]), 128'(0));
      checkOutput("async reset out_data", outData[0], 128'(0));
      checkOutput("async reset pass_cnt", 128'(passCnt[0]), 128'(0));
      @(negedge clk);
      rstN = 1'b1;
      bad  = 0;
      repeat (4) begin
         @(negedge clk);
         if (rndStart[0] || outValid[0] || busy[0]) bad++;
      end
      checkOutput("activity after reset release", 128'(bad), 128'(0));

      $display("[TB] FIPS vector, ROUND_LAT=1");
      applyStimulus(1, CT);
      waitForResult(1, 1, 23, PT);
      releaseOutput(1);

      $display("[TB] FIPS vector, ROUND_LAT=15");
      applyStimulus(2, CT);
      waitForResult(2, 15, 177, PT);
      releaseOutput(2);

      $display("test done: total=%0d bad=%0d", checkCount, badCount);
      $finish;
   end

endmodule
